// File: rtl/ro_pair_evaluator.sv
// Ring-oscillator pair evaluator: per LFSR challenge, races one RO against its complement
// over a fixed window and shifts the winner bit into the PUF response.
//
// state   | meaning
// IDLE    | waiting for start, busy low
// LOAD    | latch RO pair from challenge, clear counters, arm window timer
// COUNT   | accumulate edges of both selected ROs for WINDOW cycles
// COMPARE | shift (cnt_a > cnt_b) into response
// ADVANCE | lfsr_enable high; loop to LOAD or finish
// DONE    | resp_valid high for one cycle
module ro_pair_evaluator #(
   parameter int WINDOW    = 1024,
   parameter int CNT_W     = 16,
   parameter int RESP_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           challenge,
   input  logic [15:0]          ro_edge,
   output logic                 lfsr_enable,
   output logic                 busy,
   output logic                 resp_valid,
   output logic [RESP_BITS-1:0] response,
   output logic [CNT_W-1:0]     cnt_a,
   output logic [CNT_W-1:0]     cnt_b
);

   localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int IDX_W = $clog2(RESP_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE, LOAD, COUNT, COMPARE, ADVANCE, DONE
   } state_t;

   state_t             state;
   logic [3:0]         sel_a;
   logic [3:0]         sel_b;
   logic [WIN_W-1:0]   win_cnt;
   logic [IDX_W-1:0]   bit_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sel_a       <= '0;
         sel_b       <= '0;
         win_cnt     <= '0;
         bit_idx     <= '0;
         lfsr_enable <= 1'b0;
         busy        <= 1'b0;
         resp_valid  <= 1'b0;
         response    <= '0;
         cnt_a       <= '0;
         cnt_b       <= '0;
      end else begin
         lfsr_enable <= 1'b0;
         resp_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  response <= '0;
                  bit_idx  <= '0;
               end
            end
            LOAD: begin
               sel_a   <= challenge;
               sel_b   <= ~challenge;
               cnt_a   <= '0;
               cnt_b   <= '0;
               win_cnt <= WIN_W'(WINDOW - 1);
               state   <= COUNT;
            end
            COUNT: begin
               // counters stick at full scale instead of wrapping
               if (ro_edge[sel_a] && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
               if (ro_edge[sel_b] && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
               if (win_cnt == '0) begin
                  state <= COMPARE;
               end else begin
                  win_cnt <= win_cnt - WIN_W'(1);
               end
            end
            COMPARE: begin
               response    <= {response[RESP_BITS-2:0], (cnt_a > cnt_b)};
               bit_idx     <= bit_idx + IDX_W'(1);
               lfsr_enable <= 1'b1;
               state       <= ADVANCE;
            end
            ADVANCE: begin
               if (bit_idx == IDX_W'(RESP_BITS)) begin
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  state <= LOAD;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
